// File: rtl/serial_adder_ctrl.sv
// Sequencer feeding a bit-serial Mealy adder LSB-first, then flushing the carry.
// Optional signed overflow flag: define SERIAL_ADD_OVF_EN.
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Start,
    input  logic [WIDTH-1:0] OpA,
    input  logic [WIDTH-1:0] OpB,
    input  logic             AdderS,
    output logic             AdderA,
    output logic             AdderB,
    output logic             AdderEnable,
    output logic             AdderReset,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Sum,
    output logic             CarryOut
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic             Overflow
`endif
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        SHIFT,
        FLUSH,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             cout_q, cout_d;
    logic             bit_a, bit_b, en;
`ifdef SERIAL_ADD_OVF_EN
    logic             msba_q, msba_d;
    logic             msbb_q, msbb_d;
    logic             ovf_q, ovf_d;
`endif

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        cout_d  = cout_q;
        bit_a   = 1'b0;
        bit_b   = 1'b0;
        en      = 1'b0;
`ifdef SERIAL_ADD_OVF_EN
        msba_d  = msba_q;
        msbb_d  = msbb_q;
        ovf_d   = ovf_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (Start) begin
                    a_d     = OpA;
                    b_d     = OpB;
                    cnt_d   = '0;
                    state_d = CLEAR;
`ifdef SERIAL_ADD_OVF_EN
                    msba_d  = OpA[WIDTH-1];
                    msbb_d  = OpB[WIDTH-1];
`endif
                end
            end
            CLEAR: begin
                state_d = SHIFT;
            end
            SHIFT: begin
                bit_a = a_q[0];
                bit_b = b_q[0];
                en    = 1'b1;
                a_d   = {1'b0, a_q[WIDTH-1:1]};
                b_d   = {1'b0, b_q[WIDTH-1:1]};
                s_d   = {AdderS, s_q[WIDTH-1:1]};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                // Zero operands: AdderS now reflects the stored carry
                en      = 1'b1;
                sum_d   = s_q;
                cout_d  = AdderS;
                state_d = DONE;
`ifdef SERIAL_ADD_OVF_EN
                ovf_d   = (msba_q == msbb_q) && (s_q[WIDTH-1] != msba_q);
`endif
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            cout_q  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            msba_q  <= 1'b0;
            msbb_q  <= 1'b0;
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            cout_q  <= cout_d;
`ifdef SERIAL_ADD_OVF_EN
            msba_q  <= msba_d;
            msbb_q  <= msbb_d;
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign AdderA      = bit_a;
    assign AdderB      = bit_b;
    assign AdderEnable = en;
    assign AdderReset  = Reset | (state_q == CLEAR);
    assign Busy        = (state_q != IDLE);
    assign Done        = (state_q == DONE);
    assign Sum         = sum_q;
    assign CarryOut    = cout_q;
`ifdef SERIAL_ADD_OVF_EN
    assign Overflow    = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl with a behavioural Mealy adder.
// Overflow checks are built when SERIAL_ADD_OVF_EN is defined.
module tb_serial_adder_ctrl;

    logic       Clock;
    logic       Reset;
    logic       Start;
    logic [7:0] OpA;
    logic [7:0] OpB;
    logic       AdderS;
    logic       AdderA;
    logic       AdderB;
    logic       AdderEnable;
    logic       AdderReset;
    logic       Busy;
    logic       Done;
    logic [7:0] Sum;
    logic       CarryOut;
`ifdef SERIAL_ADD_OVF_EN
    logic       Overflow;
`endif

    int checks = 0;
    int errors = 0;
    int busy_n, en_n, done_n;

    serial_adder_ctrl #(.WIDTH(8)) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .Start       (Start),
        .OpA         (OpA),
        .OpB         (OpB),
        .AdderS      (AdderS),
        .AdderA      (AdderA),
        .AdderB      (AdderB),
        .AdderEnable (AdderEnable),
        .AdderReset  (AdderReset),
        .Busy        (Busy),
        .Done        (Done),
        .Sum         (Sum),
        .CarryOut    (CarryOut)
`ifdef SERIAL_ADD_OVF_EN
        ,
        .Overflow    (Overflow)
`endif
    );

    // Mealy serial adder: carry flop plus combinational sum
    logic carry_q;
    always @(posedge Clock) begin
        if (AdderReset)
            carry_q <= 1'b0;
        else if (AdderEnable)
            carry_q <= (AdderA & AdderB) | (AdderA & carry_q) | (AdderB & carry_q);
    end
    assign AdderS = AdderA ^ AdderB ^ carry_q;

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                          input int inj, input int rst_at, output int lat);
        int g;
        bit stop;
        g = 0;
        while (Busy && g < 40) begin
            @(negedge Clock);
            g++;
        end
        OpA   = a;
        OpB   = b;
        Start = 1'b1;
        @(negedge Clock);
        Start  = 1'b0;
        lat    = 1;
        busy_n = 0;
        en_n   = 0;
        done_n = 0;
        stop   = 1'b0;
        while (!stop) begin
            busy_n += 32'(Busy);
            en_n   += 32'(AdderEnable);
            done_n += 32'(Done);
            if (lat == 1) begin
                chk("clear_rst", 32'(AdderReset), 1);
                chk("clear_en", 32'(AdderEnable), 0);
            end
            if (Done || lat >= 20) begin
                stop = 1'b1;
            end else if (lat == rst_at) begin
                Reset = 1'b1;
                @(negedge Clock);
                lat++;
                stop = 1'b1;
            end else begin
                if (lat == inj) begin
                    Start = 1'b1;
                    OpA   = ~a;
                    OpB   = 8'h11;
                end else if (lat == inj + 1) begin
                    Start = 1'b0;
                end
                @(negedge Clock);
                lat++;
            end
        end
    endtask

    initial begin
        int lat, extra, cyc, t1, t2;
        logic [7:0] ra, rb;
        logic [8:0] exp9;

        Reset = 1'b1;
        Start = 1'b0;
        OpA   = 8'h00;
        OpB   = 8'h00;
        repeat (3) @(negedge Clock);
        chk("rst_busy", 32'(Busy), 0);
        chk("rst_done", 32'(Done), 0);
        chk("rst_sum", 32'(Sum), 0);
        chk("rst_cout", 32'(CarryOut), 0);
        chk("rst_a", 32'(AdderA), 0);
        chk("rst_b", 32'(AdderB), 0);
        chk("rst_en", 32'(AdderEnable), 0);
        chk("rst_arst", 32'(AdderReset), 1);
`ifdef SERIAL_ADD_OVF_EN
        chk("rst_ovf", 32'(Overflow), 0);
`endif
        Reset = 1'b0;
        @(negedge Clock);
        chk("idle_arst", 32'(AdderReset), 0);

        run_op(8'h5A, 8'h33, 0, 0, lat);
        chk("t1_lat", 32'(lat), 11);
        chk("t1_sum", 32'(Sum), 'h8D);
        chk("t1_cout", 32'(CarryOut), 0);
        chk("t1_busy", 32'(busy_n), 11);
        chk("t1_en", 32'(en_n), 9);
        chk("t1_done", 32'(done_n), 1);

        run_op(8'hFF, 8'h01, 0, 0, lat);
        chk("t2_sum", 32'(Sum), 'h00);
        chk("t2_cout", 32'(CarryOut), 1);

        run_op(8'h80, 8'h80, 0, 0, lat);
        chk("t2b_sum", 32'(Sum), 'h00);
        chk("t2b_cout", 32'(CarryOut), 1);
`ifdef SERIAL_ADD_OVF_EN
        chk("t2b_ovf", 32'(Overflow), 1);
`endif

        run_op(8'h12, 8'h34, 4, 0, lat);
        chk("t3_lat", 32'(lat), 11);
        chk("t3_sum", 32'(Sum), 'h46);
        chk("t3_cout", 32'(CarryOut), 0);
        chk("t3_done", 32'(done_n), 1);
        extra = 0;
        repeat (15) begin
            @(negedge Clock);
            extra += 32'(Done);
        end
        chk("t3_extra_done", 32'(extra), 0);

        run_op(8'hFF, 8'hFF, 0, 5, lat);
        chk("t4_busy", 32'(Busy), 0);
        chk("t4_done", 32'(Done), 0);
        chk("t4_sum", 32'(Sum), 0);
        chk("t4_cout", 32'(CarryOut), 0);
        chk("t4_arst", 32'(AdderReset), 1);
        chk("t4_en", 32'(AdderEnable), 0);
        Reset = 1'b0;
        @(negedge Clock);
        run_op(8'h01, 8'h01, 0, 0, lat);
        chk("t4b_lat", 32'(lat), 11);
        chk("t4b_sum", 32'(Sum), 'h02);
        chk("t4b_cout", 32'(CarryOut), 0);

        @(negedge Clock);
        OpA   = 8'h0F;
        OpB   = 8'h01;
        Start = 1'b1;
        @(negedge Clock);
        OpA = 8'h7F;
        cyc = 1;
        t1  = -1;
        t2  = -1;
        while (cyc < 40 && t2 < 0) begin
            if (Done) begin
                if (t1 < 0) begin
                    t1 = cyc;
                    chk("t5_sum1", 32'(Sum), 'h10);
`ifdef SERIAL_ADD_OVF_EN
                    chk("t5_ovf1", 32'(Overflow), 0);
`endif
                end else begin
                    t2 = cyc;
                    Start = 1'b0;
                    chk("t5_sum2", 32'(Sum), 'h80);
`ifdef SERIAL_ADD_OVF_EN
                    chk("t5_ovf2", 32'(Overflow), 1);
`endif
                end
            end
            @(negedge Clock);
            cyc++;
        end
        Start = 1'b0;
        chk("t5_first", 32'(t1), 11);
        chk("t5_gap", 32'(t2 - t1), 12);

        for (int i = 0; i < 256; i++) begin
            ra   = 8'($urandom_range(0, 255));
            rb   = 8'($urandom_range(0, 255));
            exp9 = {1'b0, ra} + {1'b0, rb};
            run_op(ra, rb, 0, 0, lat);
            chk("sweep_res", 32'({CarryOut, Sum}), 32'(exp9));
            chk("sweep_en", 32'(en_n), 9);
`ifdef SERIAL_ADD_OVF_EN
            chk("sweep_ovf", 32'(Overflow),
                32'((ra[7] == rb[7]) && (exp9[7] != ra[7])));
`endif
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
